wb_regfile: RTL and testbench
=============================

# wb_regfile

Writeback stage and integer register file for the RV32I five-stage pipeline. Consumes the MEM/WB pipeline-register outputs, selects the writeback result, and commits it into a 32×32-bit register file. Serves the two decode-stage read ports with same-cycle write-through bypass. Maintains a committed-write counter and a sticky illegal-select flag for debug.

## Interface

Parameters:
- XLEN, 32, data width of registers and result.
- NREG, 32, number of architectural registers; x0 is hardwired to zero.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- RegWriteW  input  1  write enable from MEM/WB.
- WriteBackW  input  3  result-select code from MEM/WB.
- ALUResultW, ReadDataW, PCTargetW, ImmExtW, PCPlus4W  input  XLEN each  candidate results from MEM/WB.
- RdW  input  5  destination register index.
- Rs1D, Rs2D  input  5  decode-stage source indices.
- RD1D, RD2D  output  XLEN  source operand data (combinational).
- ResultW  output  XLEN  selected writeback value (combinational).
- WriteCount  output  32  count of committed register writes.
- IllegalSel  output  1  sticky flag: an illegal WriteBackW code was seen with RegWriteW=1.

## Operation

- Result select on WriteBackW:
  - 0 → ALUResultW
  - 1 → ReadDataW
  - 2 → PCTargetW
  - 3 → ImmExtW
  - 4 → PCPlus4W
  - 5–7 → illegal; ResultW = 0.
- Commit condition: `commit = RegWriteW & (RdW != 0) & (WriteBackW <= 4)`.
- On a rising edge with commit=1:
  - regs[RdW] ← ResultW.
  - WriteCount ← WriteCount + 1, modulo 2^32, wrapping 0xFFFFFFFF → 0.
- An illegal code with RegWriteW=1:
  - Suppresses the write and does not count.
  - Sets IllegalSel=1 at the next edge; the flag holds until reset.
- Writes to x0 are dropped and not counted. x0 always reads 0.
- Read ports, evaluated independently for RD1D/Rs1D and RD2D/Rs2D:
  - If Rs == 0 → 0.
  - Else if commit and Rs == RdW → ResultW (write-through bypass).
  - Else → regs[Rs].
- Both read ports may address the same register, or the register being written, in the same cycle. Both then receive the bypassed value.

## Timing

- Reset (reset=0, asynchronous, independent of clk):
  - All regs[1..31], WriteCount and IllegalSel clear to 0 immediately.
  - RD1D, RD2D read 0. ResultW still follows its inputs combinationally.
- A commit in cycle N is visible through the bypass in cycle N and from storage in cycle N+1 onward. A RAW hazard between the WB and ID stages needs no stall.
- Writes are ignored while reset is held low. The first write is accepted at the first rising edge after reset deasserts.
- Reset asserted mid-operation discards any in-flight write at that edge. Stored contents are cleared; no partial update occurs.
- Latency:
  - ResultW, RD1D, RD2D: 0 cycles (combinational).
  - Storage, WriteCount, IllegalSel: 1 edge.
- Per cycle: at most one write and one WriteCount increment.

## Test plan

- Reset and basic write:
  - Assert reset=0 mid-run → RD1D=RD2D=0, WriteCount=0, IllegalSel=0.
  - Deassert, then write x5 with WriteBackW=0, ALUResultW=0x12345678. Next cycle, Rs1D=5 → RD1D=0x12345678 and WriteCount=1.
- Select coverage: for codes 0–4, write x1..x5 with distinct inputs (e.g. ReadDataW=0xDEADBEEF for code 1, PCPlus4W=0x104 for code 4). Read back each register → value matches its selected source; WriteCount=5.
- Bypass:
  - Same cycle: RegWriteW=1, RdW=7, ResultW=0xA5A5A5A5, Rs1D=Rs2D=7 → RD1D=RD2D=0xA5A5A5A5 combinationally.
  - With RegWriteW=0 in the same setup → both ports return the old x7 contents.
- x0: write RdW=0 with ALUResultW=0xFFFFFFFF → Rs1D=0 returns 0, no bypass, WriteCount unchanged.
- Illegal select: RegWriteW=1, WriteBackW=6, RdW=3 → ResultW=0, x3 unchanged, WriteCount unchanged, IllegalSel=1 after the edge and still 1 after 10 further legal writes.
- Counter wrap and reset mid-write:
  - Force WriteCount to 0xFFFFFFFF via 2^32−1 commits, or a bench-side preload of the equivalent state. One more commit → WriteCount=0.
  - Then pulse reset low coincident with a commit to x9 → x9 reads 0 afterwards.

Source files
------------

// File: rtl/wb_regfile.sv
// -----------------------------------------------------------------------------
// wb_regfile
//   Writeback stage and integer register file for the RV32I five-stage
//   pipeline. Selects the writeback result from the MEM/WB candidates, commits
//   it into the register file, and serves the two decode-stage read ports with
//   same-cycle write-through bypass so a WB->ID RAW hazard needs no stall.
//   Also keeps a committed-write counter and a sticky illegal-select flag.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-low reset
//   RegWriteW   write enable from MEM/WB
//   WriteBackW  result-select code (0..4 legal, 5..7 illegal)
//   ALUResultW, ReadDataW, PCTargetW, ImmExtW, PCPlus4W  candidate results
//   RdW         destination register index
//   Rs1D, Rs2D  decode-stage source indices
//   RD1D, RD2D  source operand data (combinational)
//   ResultW     selected writeback value (combinational)
//   WriteCount  number of committed register writes (wraps at 2^32)
//   IllegalSel  sticky: illegal WriteBackW seen while RegWriteW was high
// -----------------------------------------------------------------------------
module wb_regfile #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            RegWriteW,
    input  logic [2:0]      WriteBackW,
    input  logic [XLEN-1:0] ALUResultW,
    input  logic [XLEN-1:0] ReadDataW,
    input  logic [XLEN-1:0] PCTargetW,
    input  logic [XLEN-1:0] ImmExtW,
    input  logic [XLEN-1:0] PCPlus4W,
    input  logic [4:0]      RdW,
    input  logic [4:0]      Rs1D,
    input  logic [4:0]      Rs2D,
    output logic [XLEN-1:0] RD1D,
    output logic [XLEN-1:0] RD2D,
    output logic [XLEN-1:0] ResultW,
    output logic [31:0]     WriteCount,
    output logic            IllegalSel
);

    logic [XLEN-1:0] regs [NREG];
    logic [31:0]     writeCount;
    logic            illegalSel;
    logic            selLegal;
    logic            commit;
    logic            bypassEn;

    // Result select; illegal codes yield zero.
    always_comb begin
        ResultW = '0;
        case (WriteBackW)
            3'd0:    ResultW = ALUResultW;
            3'd1:    ResultW = ReadDataW;
            3'd2:    ResultW = PCTargetW;
            3'd3:    ResultW = ImmExtW;
            3'd4:    ResultW = PCPlus4W;
            default: ResultW = '0;
        endcase
    end

    assign selLegal = (WriteBackW <= 3'd4);
    assign commit   = RegWriteW && (RdW != 5'd0) && selLegal;

    // While reset is held the write is discarded, so it must not be bypassed
    // either; this keeps both read ports at zero for the whole reset window.
    assign bypassEn = commit && reset;

    always_comb begin
        RD1D = '0;
        if (!reset || Rs1D == 5'd0)
            RD1D = '0;
        else if (bypassEn && Rs1D == RdW)
            RD1D = ResultW;
        else
            RD1D = regs[Rs1D];
    end

    always_comb begin
        RD2D = '0;
        if (!reset || Rs2D == 5'd0)
            RD2D = '0;
        else if (bypassEn && Rs2D == RdW)
            RD2D = ResultW;
        else
            RD2D = regs[Rs2D];
    end

    // Storage. Entry 0 is never written, so it stays at its reset value of 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
        end else if (commit) begin
            regs[RdW] <= ResultW;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            writeCount <= '0;
            illegalSel <= 1'b0;
        end else begin
            if (commit)
                writeCount <= writeCount + 32'd1;
            if (RegWriteW && !selLegal)
                illegalSel <= 1'b1;
        end
    end

    assign WriteCount = writeCount;
    assign IllegalSel = illegalSel;

endmodule

// File: tb/tb_wb_regfile.sv
// -----------------------------------------------------------------------------
// tb_wb_regfile
//   Directed self-checking bench for wb_regfile. Inputs change just after the
//   falling edge; combinational outputs are sampled 1 ns later, registered
//   state is sampled after the following rising edge.
// -----------------------------------------------------------------------------
module tb_wb_regfile;

    logic        clk;
    logic        reset;
    logic        RegWriteW;
    logic [2:0]  WriteBackW;
    logic [31:0] ALUResultW;
    logic [31:0] ReadDataW;
    logic [31:0] PCTargetW;
    logic [31:0] ImmExtW;
    logic [31:0] PCPlus4W;
    logic [4:0]  RdW;
    logic [4:0]  Rs1D;
    logic [4:0]  Rs2D;
    logic [31:0] RD1D;
    logic [31:0] RD2D;
    logic [31:0] ResultW;
    logic [31:0] WriteCount;
    logic        IllegalSel;

    int checkCount;
    int errorCount;

    wb_regfile #(.XLEN(32), .NREG(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .RegWriteW  (RegWriteW),
        .WriteBackW (WriteBackW),
        .ALUResultW (ALUResultW),
        .ReadDataW  (ReadDataW),
        .PCTargetW  (PCTargetW),
        .ImmExtW    (ImmExtW),
        .PCPlus4W   (PCPlus4W),
        .RdW        (RdW),
        .Rs1D       (Rs1D),
        .Rs2D       (Rs2D),
        .RD1D       (RD1D),
        .RD2D       (RD2D),
        .ResultW    (ResultW),
        .WriteCount (WriteCount),
        .IllegalSel (IllegalSel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive one writeback transaction just after the falling edge.
    task automatic driveWb(input logic we, input logic [2:0] sel,
                           input logic [4:0] rd, input logic [31:0] alu);
        @(negedge clk);
        RegWriteW  = we;
        WriteBackW = sel;
        RdW        = rd;
        ALUResultW = alu;
    endtask

    // Idle the write port and look at registers on both read ports.
    task automatic readRegs(input logic [4:0] a, input logic [4:0] b);
        @(negedge clk);
        RegWriteW = 1'b0;
        Rs1D      = a;
        Rs2D      = b;
        #1;
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        reset      = 1'b0;
        RegWriteW  = 1'b0;
        WriteBackW = 3'd0;
        ALUResultW = 32'h0;
        ReadDataW  = 32'h0;
        PCTargetW  = 32'h0;
        ImmExtW    = 32'h0;
        PCPlus4W   = 32'h0;
        RdW        = 5'd0;
        Rs1D       = 5'd5;
        Rs2D       = 5'd5;

        // Power-on reset state
        repeat (2) @(negedge clk);
        #1;
        checkVal("por_count", WriteCount, 32'h0);
        checkVal("por_illegal", {31'b0, IllegalSel}, 32'h0);
        checkVal("por_rd1", RD1D, 32'h0);

        // First write after reset release: x5 <= ALU
        @(negedge clk);
        reset = 1'b1;
        driveWb(1'b1, 3'd0, 5'd5, 32'h12345678);
        #1;
        checkVal("sel0_result", ResultW, 32'h12345678);
        readRegs(5'd5, 5'd0);
        checkVal("x5_first", RD1D, 32'h12345678);
        checkVal("count_first", WriteCount, 32'd1);

        // Reset asserted mid-run clears everything asynchronously
        @(negedge clk);
        #2;
        reset = 1'b0;
        Rs1D  = 5'd5;
        Rs2D  = 5'd5;
        #1;
        checkVal("rst_rd1", RD1D, 32'h0);
        checkVal("rst_rd2", RD2D, 32'h0);
        checkVal("rst_count", WriteCount, 32'h0);
        checkVal("rst_illegal", {31'b0, IllegalSel}, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Select coverage: code k writes x(k+1)
        ALUResultW = 32'h11111111;
        ReadDataW  = 32'hDEADBEEF;
        PCTargetW  = 32'h00000200;
        ImmExtW    = 32'hFFFFF800;
        PCPlus4W   = 32'h00000104;
        for (int k = 0; k < 5; k++)
            driveWb(1'b1, 3'(k), 5'(k + 1), 32'h11111111);
        readRegs(5'd1, 5'd2);
        checkVal("x1_alu", RD1D, 32'h11111111);
        checkVal("x2_mem", RD2D, 32'hDEADBEEF);
        readRegs(5'd3, 5'd4);
        checkVal("x3_pctarget", RD1D, 32'h00000200);
        checkVal("x4_imm", RD2D, 32'hFFFFF800);
        readRegs(5'd5, 5'd5);
        checkVal("x5_pcplus4", RD1D, 32'h00000104);
        checkVal("count_sel", WriteCount, 32'd5);

        // Bypass: x7 holds an old value, then a same-cycle write is visible
        driveWb(1'b1, 3'd0, 5'd7, 32'h0BADF00D);
        driveWb(1'b1, 3'd0, 5'd7, 32'hA5A5A5A5);
        Rs1D = 5'd7;
        Rs2D = 5'd7;
        #1;
        checkVal("byp_rd1", RD1D, 32'hA5A5A5A5);
        checkVal("byp_rd2", RD2D, 32'hA5A5A5A5);
        RegWriteW = 1'b0;
        #1;
        checkVal("nobyp_rd1", RD1D, 32'h0BADF00D);
        checkVal("nobyp_rd2", RD2D, 32'h0BADF00D);
        readRegs(5'd7, 5'd7);
        checkVal("x7_kept", RD1D, 32'h0BADF00D);
        checkVal("count_byp", WriteCount, 32'd6);

        // Write to x0 is dropped
        driveWb(1'b1, 3'd0, 5'd0, 32'hFFFFFFFF);
        Rs1D = 5'd0;
        Rs2D = 5'd0;
        #1;
        checkVal("x0_nobyp", RD1D, 32'h0);
        readRegs(5'd0, 5'd0);
        checkVal("x0_read", RD2D, 32'h0);
        checkVal("x0_count", WriteCount, 32'd6);

        // Illegal codes: ResultW is zero; with RegWriteW the flag sets
        driveWb(1'b0, 3'd5, 5'd3, 32'h33333333);
        #1;
        checkVal("sel5_result", ResultW, 32'h0);
        driveWb(1'b0, 3'd7, 5'd3, 32'h33333333);
        #1;
        checkVal("sel7_result", ResultW, 32'h0);
        checkVal("illegal_idle", {31'b0, IllegalSel}, 32'h0);
        driveWb(1'b1, 3'd6, 5'd3, 32'h33333333);
        Rs1D = 5'd3;
        #1;
        checkVal("sel6_result", ResultW, 32'h0);
        checkVal("sel6_nobyp", RD1D, 32'h00000200);
        readRegs(5'd3, 5'd3);
        checkVal("illegal_set", {31'b0, IllegalSel}, 32'h1);
        checkVal("illegal_x3", RD1D, 32'h00000200);
        checkVal("illegal_count", WriteCount, 32'd6);
        for (int k = 0; k < 10; k++)
            driveWb(1'b1, 3'd0, 5'(10 + k), 32'(k + 1));
        readRegs(5'd19, 5'd10);
        checkVal("illegal_sticky", {31'b0, IllegalSel}, 32'h1);
        checkVal("count_after10", WriteCount, 32'd16);
        checkVal("x19", RD1D, 32'd10);
        checkVal("x10", RD2D, 32'd1);

        // Counter wrap from a preloaded all-ones state
        @(negedge clk);
        RegWriteW = 1'b0;
        force dut.writeCount = 32'hFFFFFFFF;
        #1;
        checkVal("preload", WriteCount, 32'hFFFFFFFF);
        release dut.writeCount;
        #1;
        RegWriteW  = 1'b1;
        WriteBackW = 3'd0;
        RdW        = 5'd8;
        ALUResultW = 32'h00000008;
        readRegs(5'd8, 5'd8);
        checkVal("count_wrap", WriteCount, 32'h0);
        checkVal("x8", RD1D, 32'h00000008);

        // Reset held low across a commit edge to x9
        driveWb(1'b1, 3'd0, 5'd9, 32'h99999999);
        Rs1D = 5'd9;
        Rs2D = 5'd9;
        #2;
        reset = 1'b0;
        #1;
        checkVal("rstw_nobyp", RD1D, 32'h0);
        @(negedge clk);
        RegWriteW = 1'b0;
        reset     = 1'b1;
        #1;
        checkVal("rstw_x9", RD1D, 32'h0);
        checkVal("rstw_count", WriteCount, 32'h0);
        checkVal("rstw_illegal", {31'b0, IllegalSel}, 32'h0);
        readRegs(5'd1, 5'd7);
        checkVal("rstw_x1", RD1D, 32'h0);
        checkVal("rstw_x7", RD2D, 32'h0);

        // First write after that release is accepted
        driveWb(1'b1, 3'd0, 5'd9, 32'h0000CAFE);
        readRegs(5'd9, 5'd9);
        checkVal("post_x9", RD2D, 32'h0000CAFE);
        checkVal("post_count", WriteCount, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
